// File: rtl/multicycle_adder_nb.sv
// Multi-cycle N-bit adder/subtractor: processes W bits per clock behind valid/ready handshakes,
// then reports the sum with carry-out, signed-overflow and zero flags.
module multicycle_adder_nb #(
    parameter int unsigned N = 32,
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         ci_i,
    input  logic         inv_b_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N-1:0] s_o,
    output logic         co_o,
    output logic         ovf_o,
    output logic         zero_o
);

    localparam int unsigned C  = N / W;
    localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    s_q, s_d;
    logic            co_q, co_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [W:0]      chunk_sum_c;
    logic            msb_carry_in_c;
    logic [N-1:0]    a_next_c;
    logic [N-1:0]    b_next_c;
    logic [N-1:0]    s_next_c;

    // Operands are consumed from the low end and shifted down; result chunks enter from the top.
    assign chunk_sum_c    = {1'b0, a_q[W-1:0]} + {1'b0, b_q[W-1:0]} + {{W{1'b0}}, carry_q};
    assign msb_carry_in_c = a_q[W-1] ^ b_q[W-1] ^ chunk_sum_c[W-1];

    generate
        if (C == 1) begin : g_single
            assign a_next_c = a_q;
            assign b_next_c = b_q;
            assign s_next_c = chunk_sum_c[W-1:0];
        end else begin : g_multi
            assign a_next_c = {{W{1'b0}}, a_q[N-1:W]};
            assign b_next_c = {{W{1'b0}}, b_q[N-1:W]};
            assign s_next_c = {chunk_sum_c[W-1:0], s_q[N-1:W]};
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        co_d        = co_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d        = a_i;
                    b_d        = inv_b_i ? ~b_i : b_i;
                    carry_d    = ci_i ^ inv_b_i;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                a_d     = a_next_c;
                b_d     = b_next_c;
                s_d     = s_next_c;
                carry_d = chunk_sum_c[W];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(C - 1)) begin
                    co_d        = chunk_sum_c[W];
                    ovf_d       = msb_carry_in_c ^ chunk_sum_c[W];
                    zero_d      = (s_next_c == '0);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            s_q         <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            co_q        <= co_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign s_o         = s_q;
    assign co_o        = co_q;
    assign ovf_o       = ovf_q;
    assign zero_o      = zero_q;

endmodule

// File: tb/tb_multicycle_adder_nb.sv
// Bench for multicycle_adder_nb: a 4-chunk instance (W=8) and a single-chunk instance (W=32).
module tb_multicycle_adder_nb;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        inv;
        logic [31:0] s;
        logic        co;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid0, in_valid1, out_ready0, out_ready1;
    logic [31:0] a, b;
    logic        ci, inv;

    logic        in_ready0, out_valid0, co0, ovf0, zero0;
    logic [31:0] s0;
    logic        in_ready1, out_valid1, co1, ovf1, zero1;
    logic [31:0] s1;

    multicycle_adder_nb #(.N(32), .W(8)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid0), .in_ready_o(in_ready0),
        .a_i(a), .b_i(b), .ci_i(ci), .inv_b_i(inv),
        .out_valid_o(out_valid0), .out_ready_i(out_ready0),
        .s_o(s0), .co_o(co0), .ovf_o(ovf0), .zero_o(zero0)
    );

    multicycle_adder_nb #(.N(32), .W(32)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .a_i(a), .b_i(b), .ci_i(ci), .inv_b_i(inv),
        .out_valid_o(out_valid1), .out_ready_i(out_ready1),
        .s_o(s1), .co_o(co1), .ovf_o(ovf1), .zero_o(zero1)
    );

    logic        sel;
    logic        obs_in_ready, obs_valid, obs_co, obs_ovf, obs_zero;
    logic [31:0] obs_s;
    assign obs_in_ready = sel ? in_ready1  : in_ready0;
    assign obs_valid    = sel ? out_valid1 : out_valid0;
    assign obs_s        = sel ? s1         : s0;
    assign obs_co       = sel ? co1        : co0;
    assign obs_ovf      = sel ? ovf1       : ovf0;
    assign obs_zero     = sel ? zero1      : zero0;

    int   checks = 0;
    int   failures = 0;
    vec_t sb[$];
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [31:0] ai, input logic [31:0] bi,
                                   input logic cii, input logic invi);
        vec_t        v;
        logic [31:0] bb;
        logic [32:0] r;
        bb     = invi ? ~bi : bi;
        r      = {1'b0, ai} + {1'b0, bb} + {32'd0, cii ^ invi};
        v.a    = ai;  v.b = bi;  v.ci = cii;  v.inv = invi;
        v.s    = r[31:0];
        v.co   = r[32];
        v.ovf  = (ai[31] == bb[31]) && (r[31] != ai[31]);
        v.zero = (r[31:0] == 32'd0);
        return v;
    endfunction

    // Drive an operation so it is accepted at the next rising edge, and record its expectation.
    task automatic accept(input vec_t v);
        @(negedge clk);
        a = v.a;  b = v.b;  ci = v.ci;  inv = v.inv;
        if (sel) in_valid1 = 1'b1; else in_valid0 = 1'b1;
        chk("in_ready_idle", 32'(obs_in_ready), 32'd1);
        @(posedge clk);
        sb.push_back(v);
        #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_result(input int exp_lat, output vec_t e);
        int lat = 0;
        while (!obs_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1");
            e = '{default: '0};
        end else begin
            e = sb.pop_front();
            chk("sum", obs_s, e.s);
            chk("co", 32'(obs_co), 32'(e.co));
            chk("ovf", 32'(obs_ovf), 32'(e.ovf));
            chk("zero", 32'(obs_zero), 32'(e.zero));
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        if (sel) out_ready1 = 1'b1; else out_ready0 = 1'b1;
        @(posedge clk);
        #1;
        out_ready0 = 1'b0;
        out_ready1 = 1'b0;
        chk("out_valid_after_release", 32'(obs_valid), 32'd0);
        chk("in_ready_after_release", 32'(obs_in_ready), 32'd1);
    endtask

    task automatic run_op(input vec_t v, input int exp_lat);
        vec_t e;
        accept(v);
        wait_result(exp_lat, e);
        release_result();
    endtask

    initial begin
        vec_t e, v2;
        tbl[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{32'h00000007, 32'h00000007, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{32'h00000010, 32'h00000010, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};

        sel = 1'b0;
        rst = 1'b1;
        in_valid0 = 1'b0;  in_valid1 = 1'b0;
        out_ready0 = 1'b0; out_ready1 = 1'b0;
        a = '0;  b = '0;  ci = 1'b0;  inv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready0), 32'd1);
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_s", s0, 32'd0);
        chk("rst_flags", {29'd0, co0, ovf0, zero0}, 32'd0);
        chk("rst_in_ready_w32", 32'(in_ready1), 32'd1);
        chk("rst_out_valid_w32", 32'(out_valid1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_op(tbl[i], 4);

        for (int i = 0; i < 6; i++)
            run_op(model($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))), 4);

        // Backpressure: result held while new requests are offered and ignored.
        accept(model(32'h0F0F0F0F, 32'h01010101, 1'b0, 1'b0));
        wait_result(4, e);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid0 = 1'b1;
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            #1;
            chk("bp_in_ready", 32'(in_ready0), 32'd0);
            chk("bp_out_valid", 32'(out_valid0), 32'd1);
            chk("bp_s_stable", s0, e.s);
            chk("bp_flags_stable", {29'd0, co0, ovf0, zero0}, {29'd0, e.co, e.ovf, e.zero});
        end
        v2 = model(32'hDEADBEEF, 32'h00C0FFEE, 1'b0, 1'b1);
        @(negedge clk);
        a = v2.a;  b = v2.b;  ci = v2.ci;  inv = v2.inv;
        out_ready0 = 1'b1;
        @(posedge clk);
        #1;
        out_ready0 = 1'b0;
        chk("bp_release_out_valid", 32'(out_valid0), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready0), 32'd1);
        @(posedge clk);
        sb.push_back(v2);
        #1;
        in_valid0 = 1'b0;
        chk("bp_new_accept", 32'(in_ready0), 32'd0);
        wait_result(4, e);
        release_result();

        // Reset in the middle of an operation discards it.
        accept(tbl[0]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        chk("midrst_in_ready", 32'(in_ready0), 32'd1);
        chk("midrst_out_valid", 32'(out_valid0), 32'd0);
        chk("midrst_s", s0, 32'd0);
        chk("midrst_flags", {29'd0, co0, ovf0, zero0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(tbl[6], 4);

        // Single-chunk instance.
        sel = 1'b1;
        run_op(tbl[1], 1);
        run_op(tbl[5], 1);
        sel = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_adder_nb.md
Name: multicycle_adder_Nb

Overview:
Sequential, parametrised successor of the combinational N-bit ripple-carry adder/subtractor. It adds or subtracts two N-bit operands W bits per clock, one chunk per cycle, so wide datapaths can meet timing with a narrow carry chain. It uses valid/ready handshakes on both sides and adds carry-out, signed-overflow and zero flags. It sits in the ALU as a multi-cycle arithmetic unit.

Parameters:
N, 32, operand/result width in bits
W, 8, chunk width processed per cycle; N % W == 0 required, W == N allowed (single chunk)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
in_valid_i  input  1  operand request valid
in_ready_o  output  1  block can accept an operation
a_i  input  N  operand a
b_i  input  N  operand b
ci_i  input  1  carry in
inv_b_i  input  1  1 = subtract: b inverted, carry-in inverted
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts result
s_o  output  N  sum/difference
co_o  output  1  carry out of bit N-1
ovf_o  output  1  signed overflow
zero_o  output  1  s_o == 0

Behaviour:
- C = N/W chunks. States: IDLE, BUSY, DONE.
- Reset (rst_i=1 at edge): state IDLE, in_ready_o=1, out_valid_o=0, s_o=0, co_o=0, ovf_o=0, zero_o=0, chunk counter=0. Reset takes priority in any state; an in-flight operation is discarded with no output.
- IDLE: in_ready_o=1. At an edge with in_valid_i=1, a_i, b_i and inv_b_i are captured. Captured b = inv_b_i ? ~b_i : b_i. Initial carry = ci_i ^ inv_b_i. Counter=0, go to BUSY.
- BUSY: in_ready_o=0, out_valid_o=0. At each edge, chunk k = bits [k*W +: W] is added: {carry, s[k]} = a[k] + b[k] + carry. k increments. At the edge processing chunk C-1, go to DONE.
- Latency: accept at edge E0; chunks processed at edges E1..EC; out_valid_o=1 from EC. C=4 gives 4 edges; W=N gives 1 edge.
- Final flags, registered at the last chunk edge:
  - co_o = carry out of bit N-1.
  - ovf_o = carry into bit N-1 XOR carry out of bit N-1.
  - zero_o = (s == 0).
- DONE: out_valid_o=1. s_o and flags are held stable, and in_ready_o=0, until an edge with out_ready_i=1, which returns the block to IDLE. in_ready_o=1 the next cycle.
- No overlap: throughput is one operation per C+2 cycles minimum.
- s_o and flags are don't-care while out_valid_o=0; intermediate chunks may appear on s_o during BUSY.
- Operand input changes after acceptance have no effect. in_valid_i is ignored outside IDLE.
- Arithmetic is modulo 2^N. Subtraction is a + ~b + ~ci: ci_i=0 with inv_b_i=1 gives a-b, and co_o=1 means no borrow.

Test Plan:
1. N=32, W=8: a=0x000000FF, b=0x1, ci=0, inv_b=0 -> s=0x00000100, co=0, ovf=0, zero=0. out_valid rises exactly 4 edges after accept.
2. a=0xFFFFFFFF, b=0x1, ci=0, inv_b=0 -> carry ripples through all 4 chunks: s=0x00000000, co=1, zero=1, ovf=0.
3. Subtract: a=5, b=7, ci=0, inv_b=1 -> s=0xFFFFFFFE, co=0, ovf=0, zero=0. Also a=7, b=7 -> s=0, co=1, zero=1.
4. Signed overflow: a=0x7FFFFFFF, b=0x1, add -> s=0x80000000, ovf=1, co=0. Then a=0x80000000, b=0x1, subtract -> s=0x7FFFFFFF, ovf=1, co=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a/b -> in_ready stays 0; s_o and flags stay stable. Raise out_ready -> IDLE, new op accepted on the next edge.
6. Reset after 2 BUSY edges -> next cycle in_ready=1, out_valid=0, s_o=0, flags 0; the following op gives a correct result. Repeat test 2 with W=32 (C=1) -> out_valid 1 edge after accept.
